// File: rtl/vga_timing_gen.sv
// VGA raster timing: 25 MHz pixel enable from a 50 MHz clock, h/v counters, registered syncs.
// Define VGA_FRAME_TICK_EN to build the once-per-frame frame_tick pulse; otherwise it is tied low.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active_pixels,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_CLK,
  output logic       frame_tick
);

  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic       pix_ce;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= ~pix_ce;
    end
  end

  // Stage 0: raster counters, advanced once per pixel
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Stage 1: registered raster outputs, one pixel behind the counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      x             <= 10'd0;
      y             <= 10'd0;
      active_pixels <= 1'b0;
      VGA_HS        <= 1'b1;
      VGA_VS        <= 1'b1;
    end else if (pix_ce) begin
      x             <= h_cnt;
      y             <= v_cnt;
      active_pixels <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      VGA_HS        <= !((h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI));
      VGA_VS        <= !((v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI));
    end
  end

  assign VGA_BLANK_N = active_pixels;
  assign VGA_CLK     = pix_ce;

`ifdef VGA_FRAME_TICK_EN
  // Registered alongside the outputs so the pulse lands with the first (0, V_VISIBLE) pixel
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_ce && (h_cnt == 10'd0) && (v_cnt == V_VIS);
    end
  end
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; expected outputs come from the elapsed clock count.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_CLK = 2 * HT * VT;
`ifdef VGA_FRAME_TICK_EN
  localparam bit TICK_EN = 1'b1;
`else
  localparam bit TICK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] x, y;
  logic       active_pixels, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, frame_tick;
  logic [25:0] obs;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;  // clk edges seen with reset released

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_CLK(VGA_CLK), .frame_tick(frame_tick)
  );

  always #10 clk = ~clk;

  assign obs = {x, y, active_pixels, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, frame_tick};

  // Pixel p is shown from the 2nd clk after release, each for two clks.
  function automatic logic [25:0] model(input int k);
    int p, h, v;
    logic act, hs, vs, tk;
    if (k < 2) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, (k == 1), 1'b0};
    p   = (k - 2) / 2;
    h   = p % HT;
    v   = (p / HT) % VT;
    act = (h < HV) && (v < VV);
    hs  = !((h >= HV + HF) && (h < HV + HF + HS));
    vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    tk  = TICK_EN && (k % 2 == 0) && (h == 0) && (v == VV);
    return {10'(h), 10'(v), act, hs, vs, act, (k % 2 == 1), tk};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst) n = 0;
    else n = n + 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (obs !== model(0)) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, obs, model(0));
      end
    end
  endtask

  task automatic test_first_pixel();
    rst = 1'b1;
    step();
    vectors++;
    if (obs !== model(n)) begin
      miscompares++;
      $display("FAIL first_clk_after_release got=%h exp=%h", obs, model(n));
    end
    step();
    vectors++;
    if ({x, y, active_pixels, VGA_CLK} !== {10'd0, 10'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL first_pixel got x=%0d y=%0d act=%b vclk=%b exp x=0 y=0 act=1 vclk=0",
               x, y, active_pixels, VGA_CLK);
    end
  endtask

  task automatic test_line();
    int hs_low = 0, act_cnt = 0, hs_x = -1, t_first = -1, t_second = -1;
    logic prev_hs = VGA_HS;
    logic [9:0] prev_x = x;
    for (int i = 0; i < 3 * HT * 2; i++) begin
      step();
      vectors++;
      if (obs !== model(n)) begin
        miscompares++;
        $display("FAIL line_model n=%0d got=%h exp=%h", n, obs, model(n));
      end
      if (i < 2 * HT) begin
        if (!VGA_HS) hs_low++;
        if (active_pixels) act_cnt++;
        if (prev_hs && !VGA_HS && hs_x < 0) hs_x = int'(x);
      end
      if (prev_x != 10'd0 && x == 10'd0) begin
        if (t_first < 0) t_first = i;
        else if (t_second < 0) t_second = i;
      end
      prev_hs = VGA_HS;
      prev_x  = x;
    end
    vectors++;
    if (hs_low !== 2 * HS) begin
      miscompares++;
      $display("FAIL hs_low_width got=%0d exp=%0d", hs_low, 2 * HS);
    end
    vectors++;
    if (hs_x !== HV + HF) begin
      miscompares++;
      $display("FAIL hs_start_x got=%0d exp=%0d", hs_x, HV + HF);
    end
    vectors++;
    if (act_cnt !== 2 * HV) begin
      miscompares++;
      $display("FAIL line_active got=%0d exp=%0d", act_cnt, 2 * HV);
    end
    vectors++;
    if (t_second - t_first !== 2 * HT) begin
      miscompares++;
      $display("FAIL line_period got=%0d exp=%0d", t_second - t_first, 2 * HT);
    end
  endtask

  task automatic test_frame();
    int vs_low = 0, act_cnt = 0, ticks = 0, t_tick = -1, tick_per = -1;
    int w_first = -1, w_second = -1;
    logic [9:0] px = x, py = y;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step();
      vectors++;
      if (obs !== model(n)) begin
        miscompares++;
        $display("FAIL frame_model n=%0d got=%h exp=%h", n, obs, model(n));
      end
      if (!VGA_VS) vs_low++;
      if (active_pixels) act_cnt++;
      if (frame_tick) begin
        ticks++;
        if (t_tick >= 0) tick_per = i - t_tick;
        t_tick = i;
      end
      if (px == 10'(HT - 1) && x != px) begin
        vectors++;
        if (x !== 10'd0 || y !== 10'((int'(py) + 1) % VT)) begin
          miscompares++;
          $display("FAIL x_wrap got x=%0d y=%0d exp x=0 y=%0d", x, y, (int'(py) + 1) % VT);
        end
        if (py == 10'(VT - 1)) begin
          if (w_first < 0) w_first = i;
          else if (w_second < 0) w_second = i;
        end
      end
      px = x;
      py = y;
    end
    vectors++;
    if (vs_low !== 2 * 2 * VS * HT) begin
      miscompares++;
      $display("FAIL vs_low_total got=%0d exp=%0d", vs_low, 2 * 2 * VS * HT);
    end
    vectors++;
    if (act_cnt !== 2 * 2 * HV * VV) begin
      miscompares++;
      $display("FAIL frame_active got=%0d exp=%0d", act_cnt, 2 * 2 * HV * VV);
    end
    vectors++;
    if (w_second - w_first !== FRAME_CLK) begin
      miscompares++;
      $display("FAIL frame_period got=%0d exp=%0d", w_second - w_first, FRAME_CLK);
    end
    vectors++;
    if (ticks !== (TICK_EN ? 2 : 0)) begin
      miscompares++;
      $display("FAIL frame_tick_count got=%0d exp=%0d", ticks, TICK_EN ? 2 : 0);
    end
    if (TICK_EN) begin
      vectors++;
      if (tick_per !== FRAME_CLK) begin
        miscompares++;
        $display("FAIL frame_tick_period got=%0d exp=%0d", tick_per, FRAME_CLK);
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0, hs_run = 0, vs_run = 0;
    while (!(x == 10'd10 && y == 10'd5) && guard < 2 * FRAME_CLK) begin
      step();
      guard++;
    end
    vectors++;
    if (guard >= 2 * FRAME_CLK) begin
      miscompares++;
      $display("FAIL mid_reset_reach got x=%0d y=%0d exp x=10 y=5", x, y);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    vectors++;
    if (obs !== model(0)) begin
      miscompares++;
      $display("FAIL mid_reset_state got=%h exp=%h", obs, model(0));
    end
    for (int i = 0; i < FRAME_CLK + 4; i++) begin
      step();
      vectors++;
      if (obs !== model(n)) begin
        miscompares++;
        $display("FAIL restart_model n=%0d got=%h exp=%h", n, obs, model(n));
      end
      if (!VGA_HS) hs_run++;
      else if (hs_run > 0) begin
        vectors++;
        if (hs_run !== 2 * HS) begin
          miscompares++;
          $display("FAIL hs_run_width got=%0d exp=%0d", hs_run, 2 * HS);
        end
        hs_run = 0;
      end
      if (!VGA_VS) vs_run++;
      else if (vs_run > 0) begin
        vectors++;
        if (vs_run !== 2 * VS * HT) begin
          miscompares++;
          $display("FAIL vs_run_width got=%0d exp=%0d", vs_run, 2 * VS * HT);
        end
        vs_run = 0;
      end
    end
  endtask

  task automatic test_random_resets();
    for (int it = 0; it < 20; it++) begin
      int run_len = $urandom_range(3000, 1);
      int rst_len = $urandom_range(6, 1);
      rst = 1'b0;
      for (int i = 0; i < rst_len; i++) begin
        step();
        vectors++;
        if (obs !== model(n)) begin
          miscompares++;
          $display("FAIL rand_reset it=%0d got=%h exp=%h", it, obs, model(n));
        end
      end
      rst = 1'b1;
      for (int i = 0; i < run_len; i++) begin
        step();
        vectors++;
        if (obs !== model(n)) begin
          miscompares++;
          $display("FAIL rand_run it=%0d n=%0d got=%h exp=%h", it, n, obs, model(n));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line();
    test_frame();
    test_mid_reset();
    test_random_resets();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
